// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the systolic-array fp16 arithmetic blocks.
package fp16_pkg;

  localparam int unsigned FP16_EXP_W  = 5;
  localparam int unsigned FP16_FRAC_W = 10;
  localparam int unsigned FP16_BIAS   = 15;
  localparam logic [15:0] FP16_QNAN   = 16'h7E00;

  // All-ones exponent field (Inf/NaN encoding)
  localparam int unsigned FP16_EXP_INF = 2 * FP16_BIAS + 1;
  // Aligned significand {imp, frac, G, R, S} and its add/sub result with carry
  localparam int unsigned SIG_W = FP16_FRAC_W + 4;
  localparam int unsigned SUM_W = SIG_W + 1;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INF
  } special_e;

endpackage

// File: rtl/sub_fp16_lzc15.sv
// Combinational 15-bit leading-zero counter; returns 15 for an all-zero input.
module lzc15 (
  input  logic [14:0] i_val,
  output logic [3:0]  o_cnt
);

  // Scan upward so the most significant set bit wins
  always_comb begin
    o_cnt = 4'd15;
    for (int i = 0; i < 15; i++) begin
      if (i_val[i]) o_cnt = 4'(14 - i);
    end
  end

endmodule

// File: rtl/sub_fp16.sv
// Pipelined binary16 subtractor (a - b), RNE rounding, valid/ready on both sides.
// Operands are captured on acceptance, then align (S1), add (S2), normalize/round (S3).
module sub_fp16
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff_out,
  output logic        ovf,
  output logic        unf
);

  localparam int unsigned EW = FP16_EXP_W;

  logic w_stall;
  logic w_en;

  // Single global enable: a held output freezes every stage
  assign w_stall  = out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = ~RST & ~w_stall;

  // ---------------- operand capture (b negated here) ----------------
  logic  r0_valid;
  fp16_t r0_a;
  fp16_t r0_b;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r0_valid <= 1'b0;
      r0_a     <= '0;
      r0_b     <= '0;
    end else if (w_en) begin
      r0_valid <= in_valid;
      if (in_valid) begin
        r0_a <= a_in;
        r0_b <= {~b_in[15], b_in[14:0]};
      end
    end
  end

  // ---------------- S1: specials, swap, align ----------------
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic             w_swap;
  fp16_t            w_x, w_y;
  logic [EW-1:0]    w_x_exp, w_y_exp, w_dexp;
  logic [SIG_W-1:0] w_x_sig, w_y_sig, w_y_al;
  logic [2*SIG_W-1:0] w_y_ext;
  special_e         w_sp;
  logic             w_sp_sign;

  assign w_a_nan = (&r0_a.exp) & (|r0_a.frac);
  assign w_b_nan = (&r0_b.exp) & (|r0_b.frac);
  assign w_a_inf = (&r0_a.exp) & ~(|r0_a.frac);
  assign w_b_inf = (&r0_b.exp) & ~(|r0_b.frac);

  always_comb begin
    w_sp      = SP_NONE;
    w_sp_sign = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r0_a.sign != r0_b.sign))) begin
      w_sp = SP_NAN;
    end else if (w_a_inf) begin
      w_sp      = SP_INF;
      w_sp_sign = r0_a.sign;
    end else if (w_b_inf) begin
      w_sp      = SP_INF;
      w_sp_sign = r0_b.sign;
    end
  end

  // Magnitude order on {exp, frac} is valid for subnormals too
  assign w_swap  = r0_b[14:0] > r0_a[14:0];
  assign w_x     = w_swap ? r0_b : r0_a;
  assign w_y     = w_swap ? r0_a : r0_b;
  assign w_x_exp = (w_x.exp == '0) ? EW'(1) : w_x.exp;
  assign w_y_exp = (w_y.exp == '0) ? EW'(1) : w_y.exp;
  assign w_dexp  = w_x_exp - w_y_exp;
  assign w_x_sig = {|w_x.exp, w_x.frac, 3'b000};
  assign w_y_sig = {|w_y.exp, w_y.frac, 3'b000};
  assign w_y_ext = {w_y_sig, SIG_W'(0)} >> w_dexp;
  assign w_y_al  = (w_dexp >= EW'(SIG_W)) ? {{(SIG_W-1){1'b0}}, |w_y_sig}
                 : {w_y_ext[2*SIG_W-1:SIG_W+1], w_y_ext[SIG_W] | (|w_y_ext[SIG_W-1:0])};

  logic             r1_valid, r1_sign, r1_sub, r1_sp_sign;
  logic [EW-1:0]    r1_exp;
  logic [SIG_W-1:0] r1_x, r1_y;
  special_e         r1_sp;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r1_valid   <= 1'b0;
      r1_sign    <= 1'b0;
      r1_sub     <= 1'b0;
      r1_sp_sign <= 1'b0;
      r1_exp     <= '0;
      r1_x       <= '0;
      r1_y       <= '0;
      r1_sp      <= SP_NONE;
    end else if (w_en) begin
      r1_valid   <= r0_valid;
      r1_sign    <= w_x.sign;
      r1_sub     <= w_x.sign ^ w_y.sign;
      r1_sp_sign <= w_sp_sign;
      r1_exp     <= w_x_exp;
      r1_x       <= w_x_sig;
      r1_y       <= w_y_al;
      r1_sp      <= w_sp;
    end
  end

  // ---------------- S2: add / subtract, leading zeros ----------------
  logic [SUM_W-1:0] w_sum;
  logic [3:0]       w_lzc;

  assign w_sum = r1_sub ? ({1'b0, r1_x} - {1'b0, r1_y}) : ({1'b0, r1_x} + {1'b0, r1_y});

  lzc15 u_lzc (
    .i_val (w_sum),
    .o_cnt (w_lzc)
  );

  logic             r2_valid, r2_sign, r2_sub, r2_sp_sign;
  logic [EW-1:0]    r2_exp;
  logic [SUM_W-1:0] r2_sum;
  logic [3:0]       r2_lzc;
  special_e         r2_sp;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r2_valid   <= 1'b0;
      r2_sign    <= 1'b0;
      r2_sub     <= 1'b0;
      r2_sp_sign <= 1'b0;
      r2_exp     <= '0;
      r2_sum     <= '0;
      r2_lzc     <= '0;
      r2_sp      <= SP_NONE;
    end else if (w_en) begin
      r2_valid   <= r1_valid;
      r2_sign    <= r1_sign;
      r2_sub     <= r1_sub;
      r2_sp_sign <= r1_sp_sign;
      r2_exp     <= r1_exp;
      r2_sum     <= w_sum;
      r2_lzc     <= w_lzc;
      r2_sp      <= r1_sp;
    end
  end

  // ---------------- S3: normalize, round, pack ----------------
  logic [EW-1:0]    w_lz1, w_ex1, w_shift;
  logic [SIG_W-1:0] w_m;
  logic [EW:0]      w_e, w_field;
  logic             w_inc;
  logic [15:0]      w_packed;
  logic [15:0]      w_res;
  logic             w_ovf, w_unf;

  assign w_lz1 = EW'(r2_lzc) - EW'(1);
  assign w_ex1 = r2_exp - EW'(1);

  always_comb begin
    w_shift = '0;
    w_m     = '0;
    w_e     = '0;
    if (r2_sum[SUM_W-1]) begin
      w_m = {r2_sum[SUM_W-1:2], r2_sum[1] | r2_sum[0]};
      w_e = (EW+1)'(r2_exp) + (EW+1)'(1);
    end else begin
      // Left shift stops at the subnormal boundary
      w_shift = (w_lz1 < w_ex1) ? w_lz1 : w_ex1;
      w_m     = r2_sum[SIG_W-1:0] << w_shift;
      w_e     = (EW+1)'(r2_exp - w_shift);
    end
  end

  // Rounding carry ripples into the exponent field: renormalizes and promotes subnormals
  assign w_field  = w_m[SIG_W-1] ? w_e : '0;
  assign w_inc    = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
  assign w_packed = {w_field, w_m[SIG_W-2:3]} + 16'(w_inc);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r2_sp == SP_NAN) begin
      w_res = FP16_QNAN;
    end else if (r2_sp == SP_INF) begin
      w_res = {r2_sp_sign, 5'h1F, 10'h000};
    end else if (r2_sum == '0) begin
      w_res = {r2_sign & ~r2_sub, 15'h0000};
    end else if (w_packed[15:10] >= 6'(FP16_EXP_INF)) begin
      w_res = {r2_sign, 5'h1F, 10'h000};
      w_ovf = 1'b1;
    end else begin
      w_res = {r2_sign, w_packed[14:0]};
      w_unf = (w_packed[15:10] == 6'd0);
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      diff_out  <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (w_en) begin
      out_valid <= r2_valid;
      diff_out  <= w_res;
      ovf       <= w_ovf;
      unf       <= w_unf;
    end
  end

endmodule

// File: tb/tb_sub_fp16.sv
// Scoreboard bench for sub_fp16: directed vectors, latency, stall/backpressure and mid-flight reset.
module tb_sub_fp16;

  logic        clk = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff_out;
  logic        ovf;
  logic        unf;

  always #5 clk = ~clk;

  sub_fp16 dut (
    .clk       (clk),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff_out  (diff_out),
    .ovf       (ovf),
    .unf       (unf)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        o;
    logic        u;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic load_vectors();
    vecs.push_back('{16'h3C00, 16'h3800, 16'h3800, 1'b0, 1'b0});
    vecs.push_back('{16'h3800, 16'h3C00, 16'hB800, 1'b0, 1'b0});
    vecs.push_back('{16'h3C00, 16'h3C00, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'h6800, 16'h3800, 16'h6800, 1'b0, 1'b0});
    vecs.push_back('{16'h3C00, 16'h0001, 16'h3C00, 1'b0, 1'b0});
    vecs.push_back('{16'h6400, 16'h3800, 16'h63FF, 1'b0, 1'b0});
    vecs.push_back('{16'h0400, 16'h0001, 16'h03FF, 1'b0, 1'b1});
    vecs.push_back('{16'h7BFF, 16'hFBFF, 16'h7C00, 1'b1, 1'b0});
    vecs.push_back('{16'h7C00, 16'h7C00, 16'h7E00, 1'b0, 1'b0});
    vecs.push_back('{16'h7C00, 16'hFC00, 16'h7C00, 1'b0, 1'b0});
    vecs.push_back('{16'h3C00, 16'h7C00, 16'hFC00, 1'b0, 1'b0});
    vecs.push_back('{16'h7E01, 16'h1234, 16'h7E00, 1'b0, 1'b0});
    vecs.push_back('{16'h3C00, 16'hFE00, 16'h7E00, 1'b0, 1'b0});
    vecs.push_back('{16'hFC00, 16'h3C00, 16'hFC00, 1'b0, 1'b0});
    vecs.push_back('{16'hC000, 16'h4000, 16'hC400, 1'b0, 1'b0});
    vecs.push_back('{16'h3C00, 16'hBC00, 16'h4000, 1'b0, 1'b0});
    vecs.push_back('{16'hBC00, 16'hBC00, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'h3555, 16'h3554, 16'h0C00, 1'b0, 1'b0});
    vecs.push_back('{16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b1});
    vecs.push_back('{16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0});
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({out_valid, diff_out, ovf, unf} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h o=%b u=%b, want all zero", out_valid, diff_out, ovf, unf);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    RST = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
    end
  endtask

  // Accepted at edge N -> out_valid only after edge N+3
  task automatic test_latency();
    logic want_v;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a_in = 16'h3C00; b_in = 16'h3800;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      want_v = (k == 4);
      n_tests++;
      if (out_valid !== want_v || (want_v && diff_out !== 16'h3800)) begin
        n_fail++;
        $display("FAIL latency_k%0d: got v=%b d=%h want v=%b d=3800", k, out_valid, diff_out, want_v);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_arith();
    int   sent = 0;
    int   got  = 0;
    vec_t e;
    sb_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 200 && got < vecs.size(); c++) begin
      @(negedge clk);
      in_valid = (sent < vecs.size());
      if (in_valid) begin
        a_in = vecs[sent].a;
        b_in = vecs[sent].b;
      end
      #1;
      if (in_valid && in_ready) begin
        sb_q.push_back(vecs[sent]);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL arith_unexpected: got d=%h with empty scoreboard", diff_out);
        end else begin
          e = sb_q.pop_front();
          if ({diff_out, ovf, unf} !== {e.d, e.o, e.u}) begin
            n_fail++;
            $display("FAIL arith %h-%h: got %h o=%b u=%b want %h o=%b u=%b",
                     e.a, e.b, diff_out, ovf, unf, e.d, e.o, e.u);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != vecs.size()) begin
      n_fail++;
      $display("FAIL arith_count: got %0d results want %0d", got, vecs.size());
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got  = 0;
    logic        holding = 1'b0;
    logic [17:0] held = '0;
    logic        dup = 1'b0;
    vec_t        e;
    sb_q.delete();
    for (int c = 0; c < 100 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c < 12);
      in_valid  = (sent < 6);
      if (in_valid) begin
        a_in = vecs[sent].a;
        b_in = vecs[sent].b;
      end
      #1;
      if (c == 4) begin
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_entry: got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
      end
      if (out_valid && !out_ready) begin
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready);
        end
        if (!holding) begin
          held    = {diff_out, ovf, unf};
          holding = 1'b1;
        end else begin
          n_tests++;
          if ({diff_out, ovf, unf} !== held) begin
            n_fail++;
            $display("FAIL stall_stable c%0d: got %h want %h", c, {diff_out, ovf, unf}, held);
          end
        end
      end else begin
        holding = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL run_in_ready c%0d: got %b want 1", c, in_ready);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(vecs[sent]);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected: got d=%h with empty scoreboard", diff_out);
        end else begin
          e = sb_q.pop_front();
          if ({diff_out, ovf, unf} !== {e.d, e.o, e.u}) begin
            n_fail++;
            $display("FAIL b2b[%0d] %h-%h: got %h want %h", got, e.a, e.b, diff_out, e.d);
          end
        end
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results want 6", got);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) dup = 1'b1;
    end
    n_tests++;
    if (dup !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_duplicate: got extra out_valid=%b want 0", dup);
    end
  endtask

  task automatic test_reset_midflight();
    logic stale = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_in = vecs[c].a;
      b_in = vecs[c].b;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || diff_out !== vecs[0].d) begin
      n_fail++;
      $display("FAIL midrst_presented: got v=%b d=%h want 1 %h", out_valid, diff_out, vecs[0].d);
    end
    RST = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || diff_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b rdy=%b d=%h want 0 0 0000", out_valid, in_ready, diff_out);
    end
    @(negedge clk);
    RST = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    n_tests++;
    if (stale !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_stale: got out_valid after reset=%b want 0", stale);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load_vectors();
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_fp16.md
# sub_fp16

Pipelined IEEE 754 binary16 subtractor (out = a − b) for the systolic array datapath. It is the inverse-direction companion to the array's fp16 adder and produces correctly signed differences for operands of either sign. It uses round-to-nearest-even with full guard/round/sticky. It has a valid/ready stream interface on both sides, so it can sit between the array's drain path and downstream accumulation without external stall logic.

## Interface
- clk  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts the pair this cycle
- a_in  input  16  minuend, binary16
- b_in  input  16  subtrahend, binary16
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- diff_out  output  16  a − b, binary16
- ovf  output  1  finite operands rounded to ±Inf; qualified by out_valid
- unf  output  1  nonzero result is subnormal or flushed to zero after rounding; qualified by out_valid
- No parameters.

## Operation
- Negate b (flip bit 15), then perform a signed-magnitude add.
- S1 (unpack/align):
  - Effective exponent is 1 for subnormals.
  - Implicit bit is 0 for exp==0, 1 otherwise.
  - Swap so the larger magnitude (exp, then fraction) is X.
  - Right-shift Y's 14-bit significand {imp,frac,G,R,S} by the exponent difference, ORing shifted-out bits into S.
  - A difference ≥ 14 leaves Y as sticky-only.
- S2 (add):
  - Same effective sign: sum, 15 bits.
  - Opposite signs: X − Y, never negative.
  - Result sign = X's sign.
  - Leading-zero count of the 15-bit result.
- S3 (normalize/round/pack):
  - On carry-out: shift right 1 with sticky, exp+1.
  - Otherwise: shift left by min(lzc, exp_eff−1); if the limit is hit, exp field = 0 (subnormal).
  - RNE: increment when G & (R | S | lsb).
  - Rounding carry renormalizes; subnormal → normal promotion is allowed.
  - exp ≥ 31 → ±Inf, ovf=1.
- Specials (decided in S1, carried through the pipe):
  - Any NaN → 0x7E00.
  - Inf − Inf, same sign → 0x7E00.
  - ±Inf − finite → a.
  - finite − ±Inf → Inf with sign opposite to b.
- Zero results:
  - Exact zero from opposite effective signs → +0 (0x0000).
  - (−0) − (+0) → 0x8000.
  - (+0) − (−0) → 0x0000.

## Timing
- Reset values:
  - in_ready = 1 once RST deasserts; it is 0 while RST is high.
  - out_valid = 0, diff_out = 0, ovf = 0, unf = 0.
  - All stage valid bits are 0.
- Latency is exactly 3 cycles. A pair accepted at edge N is presented with out_valid=1 after edge N+3 when unstalled.
- Throughput is 1 pair per cycle.
- Global stall:
  - stall = out_valid & ~out_ready.
  - When stalled, all stage registers hold and in_ready = ~stall (combinational).
  - Bubbles are not compressed under stall; the simple global enable is required.
- diff_out, ovf and unf stay stable while out_valid=1 and out_ready=0.
- Transfers occur only on valid & ready.
  - in_valid with in_ready=0 means a_in/b_in are not sampled.
  - Simultaneous output accept and input accept in the same cycle is legal and advances the whole pipe.
- RST mid-operation clears all stage valid bits immediately. In-flight results are dropped, never emitted.
- Output registers are the S3 registers; no combinational path from a_in/b_in to diff_out.

## Structure
- Shared package `fp16_pkg` contains:
  - FP16_EXP_W=5, FP16_FRAC_W=10, FP16_BIAS=15.
  - FP16_QNAN=16'h7E00.
  - Packed struct fp16_t {sign, exp, frac}.
  - Enum special_e {SP_NONE, SP_NAN, SP_INF}.
- The package is shared with the adder and multiplier.
- One sub-module `lzc15`: combinational 15-bit leading-zero counter, output 4 bits, 15 for all-zero.
- Pipeline registers, stall logic and rounding stay in sub_fp16.

## Test plan
- Basic:
  - 0x3C00 − 0x3800 → 0x3800 exactly 3 cycles after acceptance.
  - 0x3800 − 0x3C00 → 0xB800.
- Cancellation and signed zeros:
  - 0x3C00 − 0x3C00 → 0x0000.
  - 0x8000 − 0x0000 → 0x8000.
  - 0x0000 − 0x8000 → 0x0000.
- Rounding:
  - 0x6800 − 0x3800 (2048 − 0.5, tie) → 0x6800.
  - 0x3C00 − 0x0001 → 0x3C00.
  - 0x6400 − 0x3800 → 0x63FF.
- Subnormal/overflow:
  - 0x0400 − 0x0001 → 0x03FF, unf=1.
  - 0x7BFF − 0xFBFF → 0x7C00, ovf=1.
- Specials:
  - 0x7C00 − 0x7C00 → 0x7E00.
  - 0x7C00 − 0xFC00 → 0x7C00.
  - 0x3C00 − 0x7C00 → 0xFC00.
  - 0x7E01 − any → 0x7E00.
- Handshake/reset:
  - Stream 6 back-to-back pairs while holding out_ready=0 from cycle 4; in_ready falls the cycle out_valid rises.
  - diff_out stays stable while stalled.
  - Releasing out_ready yields all 6 results in order with no loss or duplication.
  - Asserting RST with 3 pairs in flight gives out_valid=0 immediately and no stale output afterwards.
